keypad_4x4_scanner: RTL and testbench

- Scanned-input peripheral for a 4x4 matrix keypad; the input-side counterpart to the multiplexed 7-segment output driver.
- Drives one keypad column low at a time and samples the four row lines.
- Debounces whole-matrix scan results and reports a 4-bit key code with a press pulse and a sticky pending flag.
- Sits in the memory-mapped peripheral space; the bus wrapper reads key_code/key_pending and strobes key_clear.

---
 rtl/keypad_4x4_scanner.sv | 146 ++++++++++++++
 tb/tb_keypad_4x4_scanner.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_4x4_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low column at a time, samples
// the synchronized rows, debounces whole-matrix scan results and reports the
// committed key with a press pulse and a sticky pending flag.
module keypad_4x4_scanner #(
  parameter int SCAN_DIV_BITS  = 15,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows,
  input  logic       key_clear,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_down,
  output logic       key_press,
  output logic       key_pending
);

  localparam logic [3:0]               CNT_MAX = 4'(DEBOUNCE_SCANS - 1);
  localparam logic [SCAN_DIV_BITS-1:0] DIV_ONE = SCAN_DIV_BITS'(1);

  typedef enum logic {S_IDLE, S_HELD} state_t;

  logic [SCAN_DIV_BITS-1:0] r_div;
  logic [3:0]               r_sync1, r_row_s;
  logic [1:0]               r_col_idx;
  logic [3:0]               r_cols;
  logic                     r_acc_found;
  logic [3:0]               r_acc_code;
  logic                     r_prev_found;
  logic [3:0]               r_prev_code;
  logic [3:0]               r_stable_cnt;
  state_t                   r_state;
  logic [3:0]               r_key_code;
  logic                     r_key_down, r_key_press, r_key_pending;

  logic       w_tick;
  logic       w_col_hit;
  logic [1:0] w_row_sel;
  logic       w_scan_found;
  logic [3:0] w_scan_code;
  logic       w_scan_end;
  logic       w_same;
  logic [3:0] w_cnt_next;
  logic       w_commit;
  logic       w_press;
  logic [1:0] w_col_next;

  // Scan-result datapath: this column's hit merged with the running scan,
  // lowest column already wins because the accumulator is only filled once.
  always_comb begin
    w_tick    = &r_div;
    w_col_hit = ~&r_row_s;
    w_row_sel = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!r_row_s[i]) w_row_sel = 2'(i);
    w_scan_found = r_acc_found | w_col_hit;
    if (r_acc_found)    w_scan_code = r_acc_code;
    else if (w_col_hit) w_scan_code = {w_row_sel, r_col_idx};
    else                w_scan_code = 4'd0;  // "no key" always carries code 0
    w_scan_end = w_tick && (r_col_idx == 2'd3);
    w_same     = ({w_scan_found, w_scan_code} == {r_prev_found, r_prev_code});
    if (!w_same)                     w_cnt_next = 4'd0;
    else if (r_stable_cnt < CNT_MAX) w_cnt_next = r_stable_cnt + 4'd1;
    else                             w_cnt_next = CNT_MAX;
    w_commit   = w_scan_end && (w_cnt_next == CNT_MAX);
    w_press    = w_commit && w_scan_found && (r_state == S_IDLE);
    w_col_next = r_col_idx + 2'd1;
  end

  // Free-running scan divider; wraps naturally after the all-ones tick.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_div <= '0;
    else        r_div <= r_div + DIV_ONE;

  // Two-flop synchronizer for the asynchronous row lines (idle high).
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync1 <= 4'hF;
      r_row_s <= 4'hF;
    end else begin
      r_sync1 <= rows;
      r_row_s <= r_sync1;
    end

  // Column walk, per-scan accumulation and consecutive-scan debounce.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_col_idx    <= 2'd0;
      r_cols       <= 4'b1110;
      r_acc_found  <= 1'b0;
      r_acc_code   <= 4'd0;
      r_prev_found <= 1'b0;
      r_prev_code  <= 4'd0;
      r_stable_cnt <= 4'd0;
    end else if (w_tick) begin
      r_col_idx <= w_col_next;
      r_cols    <= ~(4'b0001 << w_col_next);
      if (w_scan_end) begin
        r_prev_found <= w_scan_found;
        r_prev_code  <= w_scan_code;
        r_stable_cnt <= w_cnt_next;
        r_acc_found  <= 1'b0;
        r_acc_code   <= 4'd0;
      end else begin
        r_acc_found <= w_scan_found;
        r_acc_code  <= w_scan_code;
      end
    end

  // Press/release FSM with registered outputs; a set of pending beats a clear.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_key_code    <= 4'd0;
      r_key_down    <= 1'b0;
      r_key_press   <= 1'b0;
      r_key_pending <= 1'b0;
    end else begin
      r_key_press <= 1'b0;
      case (r_state)
        S_IDLE:
          if (w_press) begin
            r_key_code  <= w_scan_code;
            r_key_down  <= 1'b1;
            r_key_press <= 1'b1;
            r_state     <= S_HELD;
          end
        S_HELD:
          if (w_commit && !w_scan_found) begin
            r_key_down <= 1'b0;
            r_state    <= S_IDLE;
          end
        default: r_state <= S_IDLE;
      endcase
      if (w_press)        r_key_pending <= 1'b1;
      else if (key_clear) r_key_pending <= 1'b0;
    end

  assign cols        = r_cols;
  assign key_code    = r_key_code;
  assign key_down    = r_key_down;
  assign key_press   = r_key_press;
  assign key_pending = r_key_pending;

endmodule

// File: tb/tb_keypad_4x4_scanner.sv
// Bench for keypad_4x4_scanner: a keypad model drives the rows from the
// pressed-key mask and the column drive; expected presses go into a queue
// that a monitor drains whenever key_press fires.
module tb_keypad_4x4_scanner;
  localparam int DIV  = 3;
  localparam int DEB  = 2;
  localparam int SCAN = 4 * (1 << DIV);

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rows;
  logic       key_clear;
  logic [3:0] cols, key_code;
  logic       key_down, key_press, key_pending;
  logic [15:0] mask;  // bit r*4+c = key at row r / col c is down

  int n_chk = 0, n_fail = 0, n_press = 0;
  int exp_q[$];
  int hist[$];
  bit m_held;
  int m_code;

  keypad_4x4_scanner #(.SCAN_DIV_BITS(DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .rows(rows), .key_clear(key_clear),
    .cols(cols), .key_code(key_code), .key_down(key_down),
    .key_press(key_press), .key_pending(key_pending));

  always #5 clk = ~clk;

  // Keypad: a row is pulled low when any pressed key on it sits in a driven column.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      if (|(mask[r*4 +: 4] & ~cols)) rows[r] = 1'b0;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every press pulse must match the oldest expected code.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && key_press === 1'b1) begin
      n_press++;
      if (exp_q.size() == 0) chk("press_unexpected", int'(key_code), -1);
      else chk("press_code", int'(key_code), exp_q.pop_front());
    end
  end

  // Which key a whole scan reports: earliest column, then lowest row.
  function automatic int scan_code(input logic [15:0] m);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (m[r*4+c]) return r*4 + c;
    return -1;
  endfunction

  // One full scan of the reference: commit when the last DEB scans agree.
  task automatic model_scan(input logic [15:0] m);
    int  res;
    bit  stable;
    res = scan_code(m);
    hist.push_back(res);
    if (hist.size() > DEB) void'(hist.pop_front());
    stable = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] != res) stable = 1'b0;
    if (stable) begin
      if (!m_held && res >= 0) begin
        m_held = 1'b1; m_code = res; exp_q.push_back(res);
      end else if (m_held && res < 0) m_held = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mask = '0; key_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_press(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (key_press) seen = 1'b1;
    end
    chk(name, int'(seen), 1);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n0, bad, sel, nscan;
  bit seen;

  initial begin
    rst_n = 1'b0; mask = '0; key_clear = 1'b0;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cols", int'(cols), 4'b1110);
    chk("rst_outs", int'({key_code, key_down, key_press, key_pending}), 0);
    rst_n = 1'b1;
    cyc(7);  chk("walk0", int'(cols), 4'b1110);
    cyc(1);  chk("walk1", int'(cols), 4'b1101);
    cyc(8);  chk("walk2", int'(cols), 4'b1011);
    cyc(8);  chk("walk3", int'(cols), 4'b0111);
    cyc(8);  chk("walk4", int'(cols), 4'b1110);

    // Single press of key 9 (row 2 / col 1).
    exp_q.push_back(9);
    mask = 16'(1) << 9;
    wait_press("press9_latency", 99);
    cyc(120);
    chk("press9_code", int'(key_code), 9);
    chk("press9_down", int'(key_down), 1);
    chk("press9_pend", int'(key_pending), 1);
    mask = '0;
    seen = 1'b0;
    for (int i = 0; i < 99 && !seen; i++) begin
      @(negedge clk);
      if (!key_down) seen = 1'b1;
    end
    chk("rel9_down", int'(seen), 1);
    chk("rel9_code", int'(key_code), 9);

    // Asynchronous reset while column 2 is driven.
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (cols == 4'b1011) seen = 1'b1;
    end
    chk("col2_reached", int'(seen), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cols", int'(cols), 4'b1110);
    chk("arst_outs", int'({key_code, key_down, key_press, key_pending}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Bouncing contact on key 3 (row 0 / col 3), then a steady hold.
    n0 = n_press;
    exp_q.push_back(3);
    for (int i = 0; i < 12; i++) begin
      mask = mask ^ (16'(1) << 3);
      cyc(5);
    end
    mask = 16'(1) << 3;
    cyc(150);
    chk("bounce_presses", n_press - n0, 1);
    chk("bounce_code", int'(key_code), 3);
    mask = '0;
    cyc(120);
    chk("bounce_rel", int'(key_down), 0);

    // Short glitch on key 7 never commits.
    n0 = n_press;
    mask = 16'(1) << 7;
    cyc(20);
    mask = '0;
    cyc(120);
    chk("glitch_presses", n_press - n0, 0);

    // Two keys at once: earliest column wins; no repress until all released.
    n0 = n_press;
    exp_q.push_back(5);
    mask = (16'(1) << 14) | (16'(1) << 5);
    cyc(150);
    chk("multi_code", int'(key_code), 5);
    chk("multi_presses", n_press - n0, 1);
    mask = 16'(1) << 14;
    cyc(150);
    chk("multi_partial_presses", n_press - n0, 1);
    chk("multi_partial_down", int'(key_down), 1);
    mask = '0;
    cyc(120);
    chk("multi_rel", int'(key_down), 0);

    // Pending flag: clear, idle clear, set, set-beats-clear.
    @(negedge clk) key_clear = 1'b1;
    @(negedge clk) key_clear = 1'b0;
    chk("pend_clear", int'(key_pending), 0);
    @(negedge clk) key_clear = 1'b1;
    @(negedge clk) key_clear = 1'b0;
    chk("pend_clear_idle", int'(key_pending), 0);
    exp_q.push_back(0);
    mask = 16'(1) << 0;
    wait_press("pend_press", 120);
    #1 chk("pend_set", int'(key_pending), 1);
    mask = '0;
    cyc(120);
    @(negedge clk) key_clear = 1'b1;
    @(negedge clk) key_clear = 1'b0;
    chk("pend_clear2", int'(key_pending), 0);
    exp_q.push_back(0);
    @(negedge clk) key_clear = 1'b1;
    mask = 16'(1) << 0;
    wait_press("pend_coinc_press", 120);
    chk("pend_setwins", int'(key_pending), 1);
    key_clear = 1'b0;
    cyc(1);
    chk("pend_after", int'(key_pending), 1);
    mask = '0;
    cyc(120);

    // Long hold: one press, key_down held throughout.
    n0 = n_press;
    exp_q.push_back(10);
    mask = 16'(1) << 10;
    cyc(100);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(SCAN);
      if (key_down !== 1'b1) bad++;
    end
    chk("sat_down_drops", bad, 0);
    chk("sat_presses", n_press - n0, 1);
    mask = '0;
    cyc(120);

    // Random masks changed on scan boundaries against the reference model.
    do_reset();
    hist.delete(); hist.push_back(-1);
    m_held = 1'b0; m_code = 0;
    for (int s = 0; s < 40; s++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      mask = '0;
      else if (sel < 8) mask = 16'(1) << $urandom_range(0, 15);
      else              mask = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      nscan = $urandom_range(1, 4);
      for (int k = 0; k < nscan; k++) begin
        model_scan(mask);
        cyc(SCAN);
        chk("rand_down", int'(key_down), int'(m_held));
        chk("rand_code", int'(key_code), m_code);
      end
    end
    mask = '0;
    cyc(4 * SCAN);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
